// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the register-file slice: data/register/counter widths,
// bank encodings and the hard-wired zero register number.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int NO_W   = 5;
  localparam int CNT_W  = 2;

  // Bank select encoding used by fmode / wr_fmode / rsv_fmode.
  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FLT = 1'b1;

  // Integer register that always reads as zero.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : cpu_pkg

// File: rtl/regfile_2bank_bank.sv
// ---------------------------------------------------------------------------
// regfile_bank
// One bank of the register file: 2^NO_W x DATA_W storage, per-register
// pending-write counters, two combinational write-first read ports with busy
// flags, and a sticky reserve-overflow flag.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   wr_en/wr_no/wr_data  write-back already steered to this bank
//   rsv_en/rsv_no        reserve already steered to this bank
//   rd1_no/rd2_no        read register numbers
//   rd1_data/rd2_data    read data (write-first bypass)
//   rd1_busy/rd2_busy    register has pending write(s)
//   rsv_ovf              sticky: a reserve was dropped at saturated count
//
// HARD_ZERO = 1 makes register 0 read zero and ignore writes and reserves.
// ---------------------------------------------------------------------------
module regfile_bank
  import cpu_pkg::ZERO_REG;
#(
  parameter int DATA_W    = 32,
  parameter int NO_W      = 5,
  parameter int CNT_W     = 2,
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [NO_W-1:0]   wr_no,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [NO_W-1:0]   rsv_no,
  input  logic [NO_W-1:0]   rd1_no,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_busy,
  input  logic [NO_W-1:0]   rd2_no,
  output logic [DATA_W-1:0] rd2_data,
  output logic              rd2_busy,
  output logic              rsv_ovf
);

  localparam int               NREG    = 1 << NO_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] mem_r      [NREG];
  logic [CNT_W-1:0]  pend_r     [NREG];
  logic [CNT_W-1:0]  pend_nxt_s [NREG];
  logic              ovf_r;
  logic              ovf_set_s;
  logic              wr_eff_s;
  logic              rsv_eff_s;

  logic [NO_W-1:0]   rd_no_s   [2];
  logic [DATA_W-1:0] rd_data_s [2];
  logic              rd_busy_s [2];

  // True when the register number names the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [NO_W-1:0] no);
    return HARD_ZERO && (no == NO_W'(ZERO_REG));
  endfunction

  // Writes and reserves aimed at the hard zero register have no effect at all.
  always_comb begin
    wr_eff_s  = wr_en  && !is_zero_reg(wr_no);
    rsv_eff_s = rsv_en && !is_zero_reg(rsv_no);
  end

  // Pending-count next state: reserve increments, write decrements, both
  // cancel. A lone reserve at saturation is dropped and flags overflow; a lone
  // write at zero is an untracked write and leaves the count at zero.
  always_comb begin
    ovf_set_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      pend_nxt_s[i] = pend_r[i];
      case ({rsv_eff_s && (rsv_no == NO_W'(i)), wr_eff_s && (wr_no == NO_W'(i))})
        2'b10: begin
          if (pend_r[i] == CNT_MAX) begin
            ovf_set_s = 1'b1;
          end else begin
            pend_nxt_s[i] = pend_r[i] + CNT_ONE;
          end
        end
        2'b01: begin
          if (pend_r[i] != '0) begin
            pend_nxt_s[i] = pend_r[i] - CNT_ONE;
          end else begin
            pend_nxt_s[i] = pend_r[i];
          end
        end
        default: pend_nxt_s[i] = pend_r[i];
      endcase
    end
  end

  // Storage, pending counters and sticky overflow; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i]  <= '0;
        pend_r[i] <= '0;
      end
      ovf_r <= 1'b0;
    end else begin
      if (wr_eff_s) begin
        mem_r[wr_no] <= wr_data;
      end
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= pend_nxt_s[i];
      end
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Gather the two read ports so they share one piece of logic.
  always_comb begin
    rd_no_s[0] = rd1_no;
    rd_no_s[1] = rd2_no;
  end

  // Read data: zero register, else same-cycle write bypass, else the array.
  // Busy: pending count non-zero, except that the write retiring the last
  // outstanding reservation releases the consumer in the same cycle (unless a
  // new reservation to the same register lands in that cycle).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (is_zero_reg(rd_no_s[p])) begin
        rd_data_s[p] = '0;
      end else if (wr_eff_s && (wr_no == rd_no_s[p])) begin
        rd_data_s[p] = wr_data;
      end else begin
        rd_data_s[p] = mem_r[rd_no_s[p]];
      end
      rd_busy_s[p] = (pend_r[rd_no_s[p]] != '0) &&
                     !(wr_eff_s && (wr_no == rd_no_s[p]) &&
                       (pend_r[rd_no_s[p]] == CNT_ONE) &&
                       !(rsv_eff_s && (rsv_no == rd_no_s[p])));
    end
  end

  // Drive the named output ports from the per-port results.
  always_comb begin
    rd1_data = rd_data_s[0];
    rd1_busy = rd_busy_s[0];
    rd2_data = rd_data_s[1];
    rd2_busy = rd_busy_s[1];
    rsv_ovf  = ovf_r;
  end

endmodule : regfile_bank

// File: rtl/regfile_2bank.sv
// ---------------------------------------------------------------------------
// regfile_2bank
// Integer/float register file with a pending-write scoreboard. Two
// combinational read ports (bank flag + register number), one write-back per
// cycle, and per-register reservation tracking for read-after-write stalls.
//
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   fmode1, reg1 -> reg_out1, busy1 read port 1
//   fmode2, reg2 -> reg_out2, busy2 read port 2
//   wr_en, wr_fmode, wr_no, wr_data write-back
//   rsv_en, rsv_fmode, rsv_no       reserve (issued instruction will write)
//   rsv_ovf                         sticky reserve-dropped flag
// ---------------------------------------------------------------------------
module regfile_2bank
  import cpu_pkg::BANK_INT;
  import cpu_pkg::BANK_FLT;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NO_W   = cpu_pkg::NO_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fmode1,
  input  logic [NO_W-1:0]   reg1,
  output logic [DATA_W-1:0] reg_out1,
  output logic              busy1,
  input  logic              fmode2,
  input  logic [NO_W-1:0]   reg2,
  output logic [DATA_W-1:0] reg_out2,
  output logic              busy2,
  input  logic              wr_en,
  input  logic              wr_fmode,
  input  logic [NO_W-1:0]   wr_no,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic              rsv_fmode,
  input  logic [NO_W-1:0]   rsv_no,
  output logic              rsv_ovf
);

  logic              wr_int_s, wr_flt_s, rsv_int_s, rsv_flt_s;
  logic [DATA_W-1:0] int_d1_s, int_d2_s, flt_d1_s, flt_d2_s;
  logic              int_b1_s, int_b2_s, flt_b1_s, flt_b2_s;
  logic              int_ovf_s, flt_ovf_s;

  // Steer write and reserve strobes to the addressed bank.
  always_comb begin
    wr_int_s  = wr_en  && (wr_fmode  == BANK_INT);
    wr_flt_s  = wr_en  && (wr_fmode  == BANK_FLT);
    rsv_int_s = rsv_en && (rsv_fmode == BANK_INT);
    rsv_flt_s = rsv_en && (rsv_fmode == BANK_FLT);
  end

  regfile_bank #(
    .DATA_W   (DATA_W),
    .NO_W     (NO_W),
    .CNT_W    (CNT_W),
    .HARD_ZERO(1'b1)
  ) u_int_bank (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_int_s),
    .wr_no   (wr_no),
    .wr_data (wr_data),
    .rsv_en  (rsv_int_s),
    .rsv_no  (rsv_no),
    .rd1_no  (reg1),
    .rd1_data(int_d1_s),
    .rd1_busy(int_b1_s),
    .rd2_no  (reg2),
    .rd2_data(int_d2_s),
    .rd2_busy(int_b2_s),
    .rsv_ovf (int_ovf_s)
  );

  regfile_bank #(
    .DATA_W   (DATA_W),
    .NO_W     (NO_W),
    .CNT_W    (CNT_W),
    .HARD_ZERO(1'b0)
  ) u_flt_bank (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_flt_s),
    .wr_no   (wr_no),
    .wr_data (wr_data),
    .rsv_en  (rsv_flt_s),
    .rsv_no  (rsv_no),
    .rd1_no  (reg1),
    .rd1_data(flt_d1_s),
    .rd1_busy(flt_b1_s),
    .rd2_no  (reg2),
    .rd2_data(flt_d2_s),
    .rd2_busy(flt_b2_s),
    .rsv_ovf (flt_ovf_s)
  );

  // Select each read port's bank and merge the overflow flags.
  always_comb begin
    if (fmode1 == BANK_FLT) begin
      reg_out1 = flt_d1_s;
      busy1    = flt_b1_s;
    end else begin
      reg_out1 = int_d1_s;
      busy1    = int_b1_s;
    end
    if (fmode2 == BANK_FLT) begin
      reg_out2 = flt_d2_s;
      busy2    = flt_b2_s;
    end else begin
      reg_out2 = int_d2_s;
      busy2    = int_b2_s;
    end
    rsv_ovf = int_ovf_s | flt_ovf_s;
  end

endmodule : regfile_2bank

// File: tb/tb_regfile_2bank.sv
module tb_regfile_2bank;

  logic        clk;
  logic        rstn;
  logic        fmode1, fmode2, wr_en, wr_fmode, rsv_en, rsv_fmode;
  logic [4:0]  reg1, reg2, wr_no, rsv_no;
  logic [31:0] wr_data, reg_out1, reg_out2;
  logic        busy1, busy2, rsv_ovf;

  regfile_2bank dut (
    .clk(clk), .rstn(rstn),
    .fmode1(fmode1), .reg1(reg1), .reg_out1(reg_out1), .busy1(busy1),
    .fmode2(fmode2), .reg2(reg2), .reg_out2(reg_out2), .busy2(busy2),
    .wr_en(wr_en), .wr_fmode(wr_fmode), .wr_no(wr_no), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_fmode(rsv_fmode), .rsv_no(rsv_no),
    .rsv_ovf(rsv_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    bit          c1;
    logic [31:0] d1;
    logic        b1;
    bit          c2;
    logic [31:0] d2;
    logic        b2;
    bit          co;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, pop the expectations registered for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: stale expectation from cycle %0d at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          if (e.c1) begin
            cmp({e.name, ".reg_out1"}, reg_out1, e.d1);
            cmp({e.name, ".busy1"}, {31'd0, busy1}, {31'd0, e.b1});
          end
          if (e.c2) begin
            cmp({e.name, ".reg_out2"}, reg_out2, e.d2);
            cmp({e.name, ".busy2"}, {31'd0, busy2}, {31'd0, e.b2});
          end
          if (e.co) cmp({e.name, ".rsv_ovf"}, {31'd0, rsv_ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  // Advance to the next cycle and return all stimulus to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_fmode = 1'b0; wr_no = 5'd0; wr_data = 32'd0;
    rsv_en = 1'b0; rsv_fmode = 1'b0; rsv_no = 5'd0;
  endtask

  task automatic rd(input logic f1, input logic [4:0] r1, input logic f2, input logic [4:0] r2);
    fmode1 = f1; reg1 = r1; fmode2 = f2; reg2 = r2;
  endtask

  task automatic wr(input logic f, input logic [4:0] n, input logic [31:0] d);
    wr_en = 1'b1; wr_fmode = f; wr_no = n; wr_data = d;
  endtask

  task automatic rsv(input logic f, input logic [4:0] n);
    rsv_en = 1'b1; rsv_fmode = f; rsv_no = n;
  endtask

  task automatic expect_cyc(input string nm,
                            input bit c1, input logic [31:0] d1, input logic b1,
                            input bit c2, input logic [31:0] d2, input logic b2,
                            input bit co, input logic ovf);
    exp_t e;
    e.name = nm; e.cyc = cyc;
    e.c1 = c1; e.d1 = d1; e.b1 = b1;
    e.c2 = c2; e.d2 = d2; e.b2 = b2;
    e.co = co; e.ovf = ovf;
    sb.push_back(e);
  endtask

  localparam logic I = 1'b0;
  localparam logic F = 1'b1;

  initial begin
    rstn = 1'b0;
    wr_en = 1'b0; wr_fmode = 1'b0; wr_no = 5'd0; wr_data = 32'd0;
    rsv_en = 1'b0; rsv_fmode = 1'b0; rsv_no = 5'd0;
    rd(I, 5'd5, F, 5'd5);

    next_cycle(); rd(I, 5'd5, F, 5'd5);
    next_cycle(); rd(I, 5'd5, F, 5'd5);
    expect_cyc("reset_state", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1, 1'b0);
    next_cycle(); rstn = 1'b1; rd(I, 5'd5, F, 5'd5);
    expect_cyc("post_reset_r5_f5", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1, 1'b0);

    // Integer write, bypass and array read; float bank untouched.
    next_cycle(); rd(I, 5'd5, F, 5'd5); wr(I, 5'd5, 32'h0000_1234);
    expect_cyc("wr_r5_bypass", 1, 32'h0000_1234, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd5, F, 5'd5);
    expect_cyc("rd_r5_f5", 1, 32'h0000_1234, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);

    // Integer r0 is hard zero; reserves to it are ignored.
    next_cycle(); rd(I, 5'd0, F, 5'd0); wr(I, 5'd0, 32'hFFFF_FFFF);
    expect_cyc("wr_r0_same", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd0, F, 5'd0); rsv(I, 5'd0);
    expect_cyc("r0_after_wr", 1, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd0, I, 5'd0);
    expect_cyc("r0_rsv_not_busy", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);

    // Float f0 is an ordinary register.
    next_cycle(); rd(F, 5'd0, I, 5'd0); wr(F, 5'd0, 32'hDEAD_BEEF);
    next_cycle(); rd(F, 5'd0, I, 5'd0);
    expect_cyc("f0_ordinary", 1, 32'hDEAD_BEEF, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);

    // Bypass on both ports.
    next_cycle(); rd(F, 5'd3, F, 5'd3); wr(F, 5'd3, 32'h3F80_0000);
    expect_cyc("f3_bypass_both", 1, 32'h3F80_0000, 1'b0, 1, 32'h3F80_0000, 1'b0, 0, 1'b0);
    next_cycle(); rd(F, 5'd3, I, 5'd3);
    expect_cyc("f3_array_r3_zero", 1, 32'h3F80_0000, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);

    // Reserve f7 -> busy next cycle; write releases in the same cycle.
    next_cycle(); rd(I, 5'd1, F, 5'd7); rsv(F, 5'd7);
    expect_cyc("f7_rsv_no_bypass", 0, 32'h0, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd7, F, 5'd7);
    expect_cyc("f7_busy", 1, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0, 1'b0);
    next_cycle(); rd(I, 5'd1, F, 5'd7); wr(F, 5'd7, 32'h4000_0000);
    expect_cyc("f7_release", 0, 32'h0, 1'b0, 1, 32'h4000_0000, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd1, F, 5'd7);
    expect_cyc("f7_after", 0, 32'h0, 1'b0, 1, 32'h4000_0000, 1'b0, 0, 1'b0);

    // Saturate r9 (count 3), then overflow.
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9);
    expect_cyc("r9_rsv1", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9);
    expect_cyc("r9_rsv2", 1, 32'h0, 1'b1, 1, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9);
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9);
    expect_cyc("r9_rsv4", 1, 32'h0, 1'b1, 0, 32'h0, 1'b0, 1, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9); wr(I, 5'd9, 32'h0000_00AA);
    expect_cyc("r9_ovf_rsv_wr", 1, 32'h0000_00AA, 1'b1, 0, 32'h0, 1'b0, 1, 1'b1);
    next_cycle(); rd(I, 5'd9, F, 5'd9); wr(I, 5'd9, 32'h0000_00BB);
    expect_cyc("r9_wr_3to2", 1, 32'h0000_00BB, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); wr(I, 5'd9, 32'h0000_00CC);
    expect_cyc("r9_wr_2to1", 1, 32'h0000_00CC, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); wr(I, 5'd9, 32'h0000_00DD);
    expect_cyc("r9_wr_1to0", 1, 32'h0000_00DD, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9);
    expect_cyc("r9_idle", 1, 32'h0000_00DD, 1'b0, 1, 32'h0, 1'b0, 1, 1'b1);

    // Untracked write at count 0 must not underflow.
    next_cycle(); rd(I, 5'd9, F, 5'd9); wr(I, 5'd9, 32'h0000_00EE);
    next_cycle(); rd(I, 5'd9, F, 5'd9); rsv(I, 5'd9);
    expect_cyc("r9_no_underflow", 1, 32'h0000_00EE, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9);
    expect_cyc("r9_count1", 1, 32'h0000_00EE, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd9, F, 5'd9); wr(I, 5'd9, 32'h0000_00FF);
    expect_cyc("r9_release_cnt1", 1, 32'h0000_00FF, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);

    // Reserve and write on different registers update independently.
    next_cycle(); rd(F, 5'd2, I, 5'd4); rsv(F, 5'd2); wr(I, 5'd4, 32'h0000_0044);
    next_cycle(); rd(F, 5'd2, I, 5'd4);
    expect_cyc("indep_rsv_wr", 1, 32'h0, 1'b1, 1, 32'h0000_0044, 1'b0, 0, 1'b0);

    // r4 reserve + write streaming; same-cycle reserve blocks the release.
    next_cycle(); rd(I, 5'd4, F, 5'd3); rsv(I, 5'd4);
    next_cycle(); rd(I, 5'd4, F, 5'd3); rsv(I, 5'd4); wr(I, 5'd4, 32'h0000_0055);
    expect_cyc("r4_rsv_wr_busy", 1, 32'h0000_0055, 1'b1, 1, 32'h3F80_0000, 1'b0, 0, 1'b0);
    next_cycle(); rd(I, 5'd4, F, 5'd2); rsv(I, 5'd4); wr(I, 5'd4, 32'h0000_0066);
    next_cycle(); rstn = 1'b0; rd(I, 5'd4, F, 5'd2); rsv(I, 5'd4); wr(I, 5'd4, 32'h0000_0077);
    next_cycle(); rstn = 1'b1; rd(I, 5'd4, F, 5'd2);
    expect_cyc("after_reset_r4_f2", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1, 1'b0);
    next_cycle(); rd(I, 5'd5, F, 5'd3);
    expect_cyc("after_reset_r5_f3", 1, 32'h0, 1'b0, 1, 32'h0, 1'b0, 1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_2bank
